// File: rtl/grf_scoreboard.sv
// Register file for the pipelined core: NUM_RD bypassed read ports, one write port, per-register pending-write counters.
// Optional macro GRF_TRACE_EN enables a simulation write trace.
module grf_scoreboard #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned CNT_W  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [31:0]                wr_pc,
    input  logic                       mark_en,
    input  logic [ADDR_W-1:0]          mark_addr,
    input  logic                       flush,
    output logic                       sb_ovf
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0]   regFile [NUM_REGS];
    logic [CNT_W-1:0]    pendCnt [NUM_REGS];
    logic [NUM_REGS-1:0] decVec;

    // A write retires one pending mark only if one is outstanding; unmarked writes leave the counter at zero.
    always_comb begin
        decVec = '0;
        for (int r = 1; r < int'(NUM_REGS); r++) begin
            decVec[r] = wr_en && (wr_addr == ADDR_W'(r)) && (pendCnt[r] != '0);
        end
    end

    // Register storage, pending counters and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                regFile[r] <= '0;
                pendCnt[r] <= '0;
            end
            sb_ovf <= 1'b0;
        end else begin
            if (wr_en && (wr_addr != '0)) begin
                regFile[wr_addr] <= wr_data;
            end
            for (int r = 1; r < int'(NUM_REGS); r++) begin
                if (flush) begin
                    pendCnt[r] <= '0;
                end else if (mark_en && (mark_addr == ADDR_W'(r)) && !decVec[r]) begin
                    if (pendCnt[r] == CNT_MAX) begin
                        sb_ovf <= 1'b1;
                    end else begin
                        pendCnt[r] <= pendCnt[r] + CNT_W'(1);
                    end
                end else if (decVec[r] && !(mark_en && (mark_addr == ADDR_W'(r)))) begin
                    pendCnt[r] <= pendCnt[r] - CNT_W'(1);
                end
            end
        end
    end

    // Zero-latency reads; busy looks through a write that retires the last pending mark this cycle.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            logic [ADDR_W-1:0] sel;
            sel = rd_addr[i*ADDR_W +: ADDR_W];
            if (sel != '0) begin
                if (wr_en && (wr_addr == sel)) begin
                    rd_data[i*DATA_W +: DATA_W] = wr_data;
                end else begin
                    rd_data[i*DATA_W +: DATA_W] = regFile[sel];
                end
                rd_busy[i] = (pendCnt[sel] - CNT_W'(decVec[sel])) != '0;
            end
        end
    end

`ifdef GRF_TRACE_EN
    always @(posedge clk) begin
        if (reset && wr_en && (wr_addr != '0)) begin
            $display("@%h: $%d <= %h", wr_pc, wr_addr, wr_data);
        end
    end
`else
    logic unusedWrPc;
    assign unusedWrPc = ^wr_pc;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed self-checking bench for grf_scoreboard (default parameters).
module tb_grf_scoreboard;

    logic        clk;
    logic        reset;
    logic [9:0]  rdAddr;
    logic [63:0] rdData;
    logic [1:0]  rdBusy;
    logic        wrEn;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic [31:0] wrPc;
    logic        markEn;
    logic [4:0]  markAddr;
    logic        flush;
    logic        sbOvf;

    int checks;
    int failures;

    grf_scoreboard dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rdAddr),
        .rd_data   (rdData),
        .rd_busy   (rdBusy),
        .wr_en     (wrEn),
        .wr_addr   (wrAddr),
        .wr_data   (wrData),
        .wr_pc     (wrPc),
        .mark_en   (markEn),
        .mark_addr (markAddr),
        .flush     (flush),
        .sb_ovf    (sbOvf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #2;
        checks++;
        if (sbOvf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf: got %b want 0", sbOvf);
        end
        for (int a = 0; a < 32; a++) begin
            rdAddr = {5'(31 - a), 5'(a)};
            #1;
            checks++;
            if (rdData !== 64'h0 || rdBusy !== 2'b00) begin
                failures++;
                $display("FAIL reset_read[%0d]: data=%h busy=%b want 0/00", a, rdData, rdBusy);
            end
        end
        tick();
    endtask

    task automatic test_write_bypass();
        wrEn = 1'b1; wrAddr = 5'd3; wrData = 32'h1234; wrPc = 32'h3000;
        rdAddr = {5'd0, 5'd3};
        #2;
        checks++;
        if (rdData[31:0] !== 32'h1234 || rdData[63:32] !== 32'h0) begin
            failures++;
            $display("FAIL bypass_same_cycle: got %h want 00000000_00001234", rdData);
        end
        tick();
        wrEn = 1'b0;
        rdAddr = {5'd3, 5'd3};
        #2;
        checks++;
        if (rdData !== {32'h1234, 32'h1234} || rdBusy !== 2'b00) begin
            failures++;
            $display("FAIL write_stored: data=%h busy=%b want both 1234, busy 00", rdData, rdBusy);
        end
        wrEn = 1'b1; wrAddr = 5'd0; wrData = 32'hFFFF;
        rdAddr = {5'd0, 5'd0};
        #2;
        checks++;
        if (rdData !== 64'h0) begin
            failures++;
            $display("FAIL r0_bypass: got %h want 0", rdData);
        end
        tick();
        wrEn = 1'b0;
        #2;
        checks++;
        if (rdData !== 64'h0) begin
            failures++;
            $display("FAIL r0_write_ignored: got %h want 0", rdData);
        end
        tick();
    endtask

    task automatic test_mark_busy();
        markEn = 1'b1; markAddr = 5'd5;
        rdAddr = {5'd0, 5'd5};
        #2;
        checks++;
        if (rdBusy[0] !== 1'b0) begin
            failures++;
            $display("FAIL mark_same_cycle_busy: got %b want 0", rdBusy[0]);
        end
        tick();
        markEn = 1'b0;
        #2;
        checks++;
        if (rdBusy[0] !== 1'b1) begin
            failures++;
            $display("FAIL mark_next_cycle_busy: got %b want 1", rdBusy[0]);
        end
        tick();
        wrEn = 1'b1; wrAddr = 5'd5; wrData = 32'h55;
        #2;
        checks++;
        if (rdBusy[0] !== 1'b0 || rdData[31:0] !== 32'h55) begin
            failures++;
            $display("FAIL write_clears_busy: busy=%b data=%h want 0/00000055", rdBusy[0], rdData[31:0]);
        end
        tick();
        wrEn = 1'b0;
        #2;
        checks++;
        if (rdBusy[0] !== 1'b0 || rdData[31:0] !== 32'h55) begin
            failures++;
            $display("FAIL after_write_busy: busy=%b data=%h want 0/00000055", rdBusy[0], rdData[31:0]);
        end
        tick();
    endtask

    task automatic test_saturate();
        markEn = 1'b1; markAddr = 5'd7;
        rdAddr = {5'd0, 5'd7};
        tick();
        tick();
        tick();
        #2;
        checks++;
        if (rdBusy[0] !== 1'b1 || sbOvf !== 1'b0) begin
            failures++;
            $display("FAIL three_marks: busy=%b ovf=%b want 1/0", rdBusy[0], sbOvf);
        end
        tick();
        markEn = 1'b0;
        #2;
        checks++;
        if (sbOvf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: got %b want 1", sbOvf);
        end
        wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'h71;
        #2;
        checks++;
        if (rdBusy[0] !== 1'b1) begin
            failures++;
            $display("FAIL first_write_busy: got %b want 1", rdBusy[0]);
        end
        tick();
        wrData = 32'h72;
        #2;
        checks++;
        if (rdBusy[0] !== 1'b1) begin
            failures++;
            $display("FAIL second_write_busy: got %b want 1", rdBusy[0]);
        end
        tick();
        wrData = 32'h73;
        #2;
        checks++;
        if (rdBusy[0] !== 1'b0) begin
            failures++;
            $display("FAIL third_write_busy: got %b want 0", rdBusy[0]);
        end
        tick();
        wrEn = 1'b0;
        #2;
        checks++;
        if (rdBusy[0] !== 1'b0 || rdData[31:0] !== 32'h73 || sbOvf !== 1'b1) begin
            failures++;
            $display("FAIL after_drain: busy=%b data=%h ovf=%b want 0/00000073/1", rdBusy[0], rdData[31:0], sbOvf);
        end
        tick();
    endtask

    task automatic test_mark_write_flush();
        markEn = 1'b1; markAddr = 5'd9;
        rdAddr = {5'd9, 5'd9};
        tick();
        wrEn = 1'b1; wrAddr = 5'd9; wrData = 32'h99;
        #2;
        checks++;
        if (rdBusy !== 2'b00) begin
            failures++;
            $display("FAIL mark_write_same_busy: got %b want 00", rdBusy);
        end
        tick();
        markEn = 1'b0; wrEn = 1'b0;
        #2;
        checks++;
        if (rdBusy !== 2'b11 || rdData[63:32] !== 32'h99) begin
            failures++;
            $display("FAIL mark_write_next: busy=%b data=%h want 11/00000099", rdBusy, rdData[63:32]);
        end
        flush = 1'b1; markEn = 1'b1; markAddr = 5'd9;
        wrEn = 1'b1; wrAddr = 5'd10; wrData = 32'hA0;
        tick();
        flush = 1'b0; markEn = 1'b0; wrEn = 1'b0;
        rdAddr = {5'd10, 5'd9};
        #2;
        checks++;
        if (rdBusy !== 2'b00 || rdData[63:32] !== 32'hA0 || sbOvf !== 1'b1) begin
            failures++;
            $display("FAIL flush: busy=%b data10=%h ovf=%b want 00/000000a0/1", rdBusy, rdData[63:32], sbOvf);
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        markEn = 1'b1; markAddr = 5'd12;
        wrEn = 1'b1; wrAddr = 5'd12; wrData = 32'hAAAA;
        tick();
        reset = 1'b0;
        wrData = 32'hBBBB;
        tick();
        reset = 1'b1; markEn = 1'b0; wrEn = 1'b0;
        rdAddr = {5'd3, 5'd12};
        #2;
        checks++;
        if (rdData !== 64'h0 || rdBusy !== 2'b00 || sbOvf !== 1'b0) begin
            failures++;
            $display("FAIL reset_midstream: data=%h busy=%b ovf=%b want 0/00/0", rdData, rdBusy, sbOvf);
        end
        tick();
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; rdAddr = '0; wrEn = 1'b0; wrAddr = '0; wrData = '0; wrPc = '0;
        markEn = 1'b0; markAddr = '0; flush = 1'b0;
        tick();
        test_reset();
        test_write_bypass();
        test_mark_busy();
        test_saturate();
        test_mark_write_flush();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
